// File: rtl/accelerator_standard_lstm_sequencer.sv
// accelerator_standard_lstm_sequencer
// Turns one flat host word stream into the ordered W, U, B, X, H parameter
// loads of the standard-LSTM controller, pulses START, forwards the H_OUT
// results and reports completion plus a result-count mismatch.
// Optional WAIT-phase watchdog: define ACCELERATOR_STANDARD_LSTM_SEQUENCER_TIMEOUT_EN.
module accelerator_standard_lstm_sequencer #(
   parameter int DATA_SIZE      = 64,
   parameter int CONTROL_SIZE   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 SEQ_START,
   output logic                 SEQ_BUSY,
   output logic                 SEQ_DONE,
   output logic                 SEQ_COUNT_ERROR,
   output logic                 SEQ_TIMEOUT,
   input  logic [DATA_SIZE-1:0] SIZE_X_IN,
   input  logic [DATA_SIZE-1:0] SIZE_L_IN,
   input  logic [DATA_SIZE-1:0] IN_DATA,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   output logic [DATA_SIZE-1:0] OP_DATA,
   output logic                 W_IN_L_ENABLE,
   output logic                 W_IN_X_ENABLE,
   output logic                 U_IN_L_ENABLE,
   output logic                 U_IN_P_ENABLE,
   output logic                 B_IN_ENABLE,
   output logic                 X_IN_ENABLE,
   output logic                 H_IN_ENABLE,
   output logic                 START,
   input  logic                 READY,
   input  logic                 H_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] H_OUT,
   output logic [DATA_SIZE-1:0] RESULT_DATA,
   output logic                 RESULT_VALID
);

   typedef enum logic [CONTROL_SIZE-1:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_LOAD_U,
      ST_LOAD_B,
      ST_LOAD_X,
      ST_LOAD_H,
      ST_KICK,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [DATA_SIZE-1:0] r_size_x;
   logic [DATA_SIZE-1:0] r_size_l;
   logic [DATA_SIZE-1:0] r_i;
   logic [DATA_SIZE-1:0] r_j;
   logic [DATA_SIZE-1:0] r_count;
   logic                 r_count_err;
   logic [DATA_SIZE-1:0] r_op_data;
   logic                 r_w_l_en;
   logic                 r_w_x_en;
   logic                 r_u_l_en;
   logic                 r_u_p_en;
   logic                 r_b_en;
   logic                 r_x_en;
   logic                 r_h_en;
   logic                 r_start;
   logic [DATA_SIZE-1:0] r_result_data;
   logic                 r_result_valid;

   logic                 w_in_load;
   logic                 w_xfer;
   logic [DATA_SIZE-1:0] w_inner_last;
   logic [DATA_SIZE-1:0] w_outer_last;
   logic                 w_two_d;
   logic                 w_j_wrap;
   logic                 w_phase_last;
   logic                 w_timeout_hit;

   // First non-empty load phase strictly after 'cur' (ST_IDLE = before all);
   // KICK when every remaining phase is empty. Later phases are tested first
   // so the earliest non-empty one overrides.
   function automatic state_t next_phase(input state_t cur, input logic x_zero,
                                         input logic l_zero);
      state_t nxt;
      nxt = ST_KICK;
      if ((cur inside {ST_IDLE, ST_LOAD_W, ST_LOAD_U, ST_LOAD_B, ST_LOAD_X}) && !l_zero)
         nxt = ST_LOAD_H;
      if ((cur inside {ST_IDLE, ST_LOAD_W, ST_LOAD_U, ST_LOAD_B}) && !x_zero)
         nxt = ST_LOAD_X;
      if ((cur inside {ST_IDLE, ST_LOAD_W, ST_LOAD_U}) && !l_zero)
         nxt = ST_LOAD_B;
      if ((cur inside {ST_IDLE, ST_LOAD_W}) && !l_zero)
         nxt = ST_LOAD_U;
      if ((cur == ST_IDLE) && !l_zero && !x_zero)
         nxt = ST_LOAD_W;
      return nxt;
   endfunction

   assign w_in_load = (r_state inside {ST_LOAD_W, ST_LOAD_U, ST_LOAD_B, ST_LOAD_X, ST_LOAD_H});
   assign w_xfer    = IN_VALID && w_in_load;

   // Index limits of the current phase; products L*X / L*L are never formed.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_inner_last = '0;
      w_outer_last = '0;
      w_two_d      = 1'b0;
      case (r_state)
         ST_LOAD_W: begin
            w_inner_last = r_size_x - 1'b1;
            w_outer_last = r_size_l - 1'b1;
            w_two_d      = 1'b1;
         end
         ST_LOAD_U: begin
            w_inner_last = r_size_l - 1'b1;
            w_outer_last = r_size_l - 1'b1;
            w_two_d      = 1'b1;
         end
         ST_LOAD_B, ST_LOAD_H: w_inner_last = r_size_l - 1'b1;
         ST_LOAD_X:            w_inner_last = r_size_x - 1'b1;
         default:              w_inner_last = '0;
      endcase
   end

   assign w_j_wrap     = (r_j == w_inner_last);
   assign w_phase_last = w_j_wrap && (!w_two_d || (r_i == w_outer_last));

`ifdef ACCELERATOR_STANDARD_LSTM_SEQUENCER_TIMEOUT_EN
   logic [DATA_SIZE-1:0] r_wd;
   logic                 r_timeout;

   assign w_timeout_hit = (r_wd == DATA_SIZE'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts WAIT cycles, sticky flag on expiry without READY.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && SEQ_START) r_timeout <= 1'b0;
         if (r_state == ST_KICK) r_wd <= '0;
         if (r_state == ST_WAIT) begin
            r_wd <= r_wd + 1'b1;
            if (w_timeout_hit && !READY) r_timeout <= 1'b1;
         end
      end
   end

   assign SEQ_TIMEOUT = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign SEQ_TIMEOUT   = 1'b0;
`endif

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!RST) r_state <= ST_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:
            if (SEQ_START)
               w_state_next = next_phase(ST_IDLE, SIZE_X_IN == '0, SIZE_L_IN == '0);
         ST_LOAD_W, ST_LOAD_U, ST_LOAD_B, ST_LOAD_X, ST_LOAD_H:
            if (w_xfer && w_phase_last)
               w_state_next = next_phase(r_state, r_size_x == '0, r_size_l == '0);
         ST_KICK: w_state_next = ST_WAIT;
         ST_WAIT:
            if (READY || w_timeout_hit) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: size latch, indices, load pulses, START, result capture, count check.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_size_x       <= '0;
         r_size_l       <= '0;
         r_i            <= '0;
         r_j            <= '0;
         r_count        <= '0;
         r_count_err    <= 1'b0;
         r_op_data      <= '0;
         r_w_l_en       <= 1'b0;
         r_w_x_en       <= 1'b0;
         r_u_l_en       <= 1'b0;
         r_u_p_en       <= 1'b0;
         r_b_en         <= 1'b0;
         r_x_en         <= 1'b0;
         r_h_en         <= 1'b0;
         r_start        <= 1'b0;
         r_result_data  <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_w_l_en       <= 1'b0;
         r_w_x_en       <= 1'b0;
         r_u_l_en       <= 1'b0;
         r_u_p_en       <= 1'b0;
         r_b_en         <= 1'b0;
         r_x_en         <= 1'b0;
         r_h_en         <= 1'b0;
         r_result_valid <= 1'b0;
         r_start        <= (r_state == ST_KICK);

         if (r_state == ST_IDLE && SEQ_START) begin
            r_size_x    <= SIZE_X_IN;
            r_size_l    <= SIZE_L_IN;
            r_i         <= '0;
            r_j         <= '0;
            r_count     <= '0;
            r_count_err <= 1'b0;
         end

         if (w_xfer) begin
            r_op_data <= IN_DATA;
            r_w_x_en  <= (r_state == ST_LOAD_W);
            r_w_l_en  <= (r_state == ST_LOAD_W) && (r_j == '0);
            r_u_p_en  <= (r_state == ST_LOAD_U);
            r_u_l_en  <= (r_state == ST_LOAD_U) && (r_j == '0);
            r_b_en    <= (r_state == ST_LOAD_B);
            r_x_en    <= (r_state == ST_LOAD_X);
            r_h_en    <= (r_state == ST_LOAD_H);
            if (w_phase_last) begin
               r_i <= '0;
               r_j <= '0;
            end else if (w_j_wrap) begin
               r_j <= '0;
               r_i <= r_i + 1'b1;
            end else begin
               r_j <= r_j + 1'b1;
            end
         end

         if (r_state == ST_WAIT && H_OUT_ENABLE) begin
            r_result_data  <= H_OUT;
            r_result_valid <= 1'b1;
            r_count        <= r_count + 1'b1;
         end

         if (r_state == ST_DONE) r_count_err <= (r_count != r_size_l);
      end
   end

   assign SEQ_BUSY        = (r_state != ST_IDLE);
   assign SEQ_DONE        = (r_state == ST_DONE);
   assign SEQ_COUNT_ERROR = r_count_err;
   assign IN_READY        = w_in_load;
   assign OP_DATA         = r_op_data;
   assign W_IN_L_ENABLE   = r_w_l_en;
   assign W_IN_X_ENABLE   = r_w_x_en;
   assign U_IN_L_ENABLE   = r_u_l_en;
   assign U_IN_P_ENABLE   = r_u_p_en;
   assign B_IN_ENABLE     = r_b_en;
   assign X_IN_ENABLE     = r_x_en;
   assign H_IN_ENABLE     = r_h_en;
   assign START           = r_start;
   assign RESULT_DATA     = r_result_data;
   assign RESULT_VALID    = r_result_valid;

endmodule
